negedge_event_arb: RTL and testbench
====================================

// Module: negedge_event_arb
// PURPOSE
//  Detects falling edges on N_CH asynchronous-free (already synchronised) inputs using the
//  team's delayed-compare scheme: edge = din_z & ~din. Latches each edge as a pending event.
//  Serialises pending events onto one valid/ready event port by round-robin arbitration.
//  Sits between per-channel strobe lines and a single downstream event consumer (IRQ/log FIFO).
// PARAMETERS
//  N_CH    4  number of input channels (>=2)
//  CHAN_W  2  width of channel index, = clog2(N_CH)
//  CNT_W   8  width of drop counter (used only with NEGEDGE_ARB_DROP_CNT_EN)
// PORTS
//  clk           in   1       clock; all logic on posedge
//  rst_n         in   1       asynchronous, active-low reset
//  en            in   1       1 = edge detection enabled; 0 = edges ignored, pending kept
//  din           in   N_CH    channel inputs, synchronous to clk
//  evt_valid     out  1       event available (registered)
//  evt_ready     in   1       consumer accepts event when evt_valid & evt_ready at posedge
//  evt_chan      out  CHAN_W  channel index of presented event (registered)
//  pend          out  N_CH    pending-event bitmap (registered)
//  drop          out  1       1-cycle pulse: an edge was lost (channel already pending)
//  drop_cnt_clr  in   1       [NEGEDGE_ARB_DROP_CNT_EN only] synchronous clear of drop_cnt
//  drop_cnt      out  CNT_W   [NEGEDGE_ARB_DROP_CNT_EN only] saturating count of drops
// BEHAVIOUR
//  Reset (async, rst_n=0): din_z=0, pend=0, evt_valid=0, evt_chan=0, drop=0, ptr=N_CH-1,
//   state=IDLE, drop_cnt=0. din_z=0 guarantees no false edge on reset release.
//  Edge detect: din_z[i] <= din[i] every cycle (also when en=0); edge[i] = en & din_z[i] & ~din[i].
//  Pending: pend[i] set at posedge when edge[i]; cleared when channel i is loaded into the
//   output register. Edge on i in the same cycle i is loaded -> pend[i] stays 1 (new event).
//  Drop: edge[i] while pend[i]=1 and i not loaded that cycle -> event lost, drop=1 next cycle.
//   Multiple simultaneous drops -> one pulse, counter +1.
//  Arbitration: round-robin; search starts at ptr+1 and wraps at N_CH-1 -> 0; first set pend
//   bit wins; ptr <= winner on load. After reset channel 0 has highest priority.
//  FSM: IDLE  - evt_valid=0; if |pend: load winner into evt_chan, clear its pend, evt_valid<=1,
//               -> PRESENT.
//       PRESENT - evt_valid=1, evt_chan held stable while evt_ready=0 (no retraction).
//               on evt_valid&evt_ready: if |pend (post-clear) load next winner same cycle,
//               stay PRESENT (1 event/cycle throughput); else evt_valid<=0 -> IDLE.
//  Latency: din low before posedge k with din_z=1 -> pend[i]=1 after k -> evt_valid=1 after k+1.
//  en=0: new edges masked; pending events and FSM continue to drain normally.
//  All N_CH channels falling in one cycle: all pend set, granted in order ptr+1.. wrapping.
//  rst_n asserted mid-handshake: evt_valid drops immediately (async); event is lost.
// CONFIGURATION
//  NEGEDGE_ARB_DROP_CNT_EN defined: drop_cnt_clr/drop_cnt ports exist; drop_cnt increments on
//   every drop pulse, saturates at 2**CNT_W-1; drop_cnt_clr=1 zeroes it (clear wins over incr).
//  Not defined: ports and counter absent; drop pulse output unchanged.
// TESTING
//  1 Reset release with din=all 1s, then idle 10 cycles -> evt_valid=0, pend=0, drop=0.
//  2 din[2] 1->0, evt_ready=1 -> evt_valid=1, evt_chan=2 two cycles later, 1 cycle wide.
//  3 din 4'hF->4'h0 same cycle, evt_ready=1 -> evt_chan 0,1,2,3 on consecutive cycles, no drop.
//  4 evt_ready=0, din[1] falls twice (rise between) -> first held on port, second pends, none dropped;
//    third fall before accept -> drop=1 pulse (drop_cnt=1 with macro).
//  5 en=0, din[3] falls -> no pend, no event; en=1 afterwards with din static -> still no event.
//  6 With macro: 300 drops, CNT_W=8 -> drop_cnt=255; drop_cnt_clr=1 -> drop_cnt=0 next cycle.

Source files
------------

// File: rtl/negedge_event_arb.sv
// Falling-edge detector with per-channel pending latches, serialised onto one valid/ready
// event port by round-robin arbitration. Optional drop counter: NEGEDGE_ARB_DROP_CNT_EN.
module negedge_event_arb #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CHAN_W = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_CH-1:0]   din,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CHAN_W-1:0] evt_chan,
  output logic [N_CH-1:0]   pend,
  output logic              drop
`ifdef NEGEDGE_ARB_DROP_CNT_EN
  ,
  input  logic              drop_cnt_clr,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  if (N_CH < 2 || CHAN_W != $clog2(N_CH) || CNT_W < 1) begin : g_param_check
    $error("negedge_event_arb: illegal N_CH/CHAN_W/CNT_W combination");
  end

  state_t            r_state;
  logic [N_CH-1:0]   r_din_z;
  logic [N_CH-1:0]   r_pend;
  logic              r_valid;
  logic [CHAN_W-1:0] r_chan;
  logic [CHAN_W-1:0] r_ptr;
  logic              r_drop;

  logic [N_CH-1:0]   w_edge;
  logic [N_CH-1:0]   w_load_mask;
  logic [N_CH-1:0]   w_pend_nxt;
  logic              w_win_found;
  logic [CHAN_W-1:0] w_win;
  logic              w_load;
  logic              w_drop;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_win_found = 1'b0;
    w_win       = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      int unsigned idx;
      idx = (32'(r_ptr) + k) % N_CH;
      if (!w_win_found && r_pend[idx]) begin
        w_win_found = 1'b1;
        w_win       = CHAN_W'(idx);
      end
    end
  end

  // The output slot is free when idle or when the presented event is being accepted.
  assign w_load      = w_win_found && ((r_state == S_IDLE) || evt_ready);
  assign w_load_mask = w_load ? (N_CH'(1) << w_win) : '0;
  assign w_edge      = {N_CH{en}} & r_din_z & ~din;
  assign w_pend_nxt  = (r_pend & ~w_load_mask) | w_edge;
  assign w_drop      = |(w_edge & r_pend & ~w_load_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_din_z <= '0;
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_ptr   <= CHAN_W'(N_CH - 1);
      r_drop  <= 1'b0;
    end else begin
      r_din_z <= din;
      r_pend  <= w_pend_nxt;
      r_drop  <= w_drop;
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_chan  <= w_win;
            r_ptr   <= w_win;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (evt_ready) begin
            if (w_load) begin
              r_chan <= w_win;
              r_ptr  <= w_win;
            end else begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid = r_valid;
  assign evt_chan  = r_chan;
  assign pend      = r_pend;
  assign drop      = r_drop;

`ifdef NEGEDGE_ARB_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  // Saturating drop counter; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (drop_cnt_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_negedge_event_arb.sv
// Self-checking bench for negedge_event_arb: directed scenarios plus randomized traffic
// compared against a channel-level behavioural model.
module tb_negedge_event_arb;

  localparam int unsigned N      = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int          CNTMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] din = 4'hF;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_chan;
  logic [3:0] pend;
  logic       drop;
  logic       drop_cnt_clr = 1'b0;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  negedge_event_arb #(.N_CH(N), .CHAN_W(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .din          (din),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_chan     (evt_chan),
    .pend         (pend)
`ifdef NEGEDGE_ARB_DROP_CNT_EN
    ,
    .drop         (drop),
    .drop_cnt_clr (drop_cnt_clr),
    .drop_cnt     (drop_cnt)
`else
    ,
    .drop         (drop)
`endif
  );

`ifndef NEGEDGE_ARB_DROP_CNT_EN
  assign drop_cnt = 8'h00;
`endif

  always #5 clk = ~clk;

  // Behavioural model: per-channel pending flags, one presented event, last-granted channel.
  bit         m_pend [N];
  bit         m_prev [N];
  bit         m_valid;
  int         m_chan;
  int         m_last;
  bit         m_drop;
  int         m_cnt;
  bit         mf_edge [N];
  int         m_grant;
  bit         m_free;
  bit         m_dropped;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_chan  = 0;
      m_last  = N - 1;
      m_drop  = 1'b0;
      m_cnt   = 0;
    end else begin
      for (int i = 0; i < N; i++) mf_edge[i] = en && m_prev[i] && !din[i];
      m_free  = !m_valid || evt_ready;
      m_grant = -1;
      if (m_free) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (m_grant < 0 && m_pend[c]) m_grant = c;
        end
      end
      m_dropped = 1'b0;
      for (int i = 0; i < N; i++)
        if (mf_edge[i] && m_pend[i] && i != m_grant) m_dropped = 1'b1;
      if (m_grant >= 0) begin
        m_pend[m_grant] = 1'b0;
        m_valid = 1'b1;
        m_chan  = m_grant;
        m_last  = m_grant;
      end else if (m_free) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) if (mf_edge[i]) m_pend[i] = 1'b1;
      m_drop = m_dropped;
      if (drop_cnt_clr) m_cnt = 0;
      else if (m_dropped && m_cnt < CNTMAX) m_cnt++;
      for (int i = 0; i < N; i++) m_prev[i] = din[i];
    end
  end

  function automatic logic [3:0] model_pend();
    logic [3:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    evt_ready = 1'b0;
    din = 4'hF;
    drop_cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din = 4'hF;
    #3;
    n_cmp++;
    if (evt_valid !== 1'b0 || pend !== 4'h0 || drop !== 1'b0 || evt_chan !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b pend=%h drop=%b chan=%0d, need 0/0/0/0",
               evt_valid, pend, drop, evt_chan);
    end
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (evt_valid !== 1'b0 || pend !== 4'h0 || drop !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: valid=%b pend=%h drop=%b, need 0/0/0",
                 c, evt_valid, pend, drop);
      end
    end
  endtask

  task automatic test_single_edge();
    do_reset();
    evt_ready = 1'b1;
    tick();
    din = 4'hB;
    tick();
    n_cmp++;
    if (pend !== 4'h4 || evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pend: pend=%h valid=%b, need 4/0", pend, evt_valid);
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_chan !== 2'd2 || pend !== 4'h0) begin
      n_err++;
      $display("FAIL single_evt: valid=%b chan=%0d pend=%h, need 1/2/0", evt_valid, evt_chan, pend);
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_width: valid=%b, need 0", evt_valid);
    end
  endtask

  task automatic test_all_fall();
    do_reset();
    evt_ready = 1'b1;
    tick();
    din = 4'h0;
    tick();
    n_cmp++;
    if (pend !== 4'hF) begin
      n_err++;
      $display("FAIL allfall_pend: pend=%h, need f", pend);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_chan !== 2'(c) || drop !== 1'b0) begin
        n_err++;
        $display("FAIL allfall_seq%0d: valid=%b chan=%0d drop=%b, need 1/%0d/0",
                 c, evt_valid, evt_chan, drop, c);
      end
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0 || pend !== 4'h0) begin
      n_err++;
      $display("FAIL allfall_end: valid=%b pend=%h, need 0/0", evt_valid, pend);
    end
  endtask

  task automatic test_hold_drop();
    do_reset();
    tick();
    din = 4'hD;
    tick();
    din = 4'hF;
    tick();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_chan !== 2'd1 || pend !== 4'h0) begin
      n_err++;
      $display("FAIL hold_first: valid=%b chan=%0d pend=%h, need 1/1/0", evt_valid, evt_chan, pend);
    end
    din = 4'hD;
    tick();
    n_cmp++;
    if (pend !== 4'h2 || drop !== 1'b0) begin
      n_err++;
      $display("FAIL hold_second: pend=%h drop=%b, need 2/0", pend, drop);
    end
    din = 4'hF;
    tick();
    din = 4'hD;
    tick();
    n_cmp++;
    if (drop !== 1'b1 || pend !== 4'h2 || evt_valid !== 1'b1 || evt_chan !== 2'd1) begin
      n_err++;
      $display("FAIL hold_drop: drop=%b pend=%h valid=%b chan=%0d, need 1/2/1/1",
               drop, pend, evt_valid, evt_chan);
    end
    tick();
    n_cmp++;
    if (drop !== 1'b0) begin
      n_err++;
      $display("FAIL hold_drop_pulse: drop=%b, need 0", drop);
    end
`ifdef NEGEDGE_ARB_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL hold_drop_cnt: drop_cnt=%0d, need 1", drop_cnt);
    end
`endif
    evt_ready = 1'b1;
    tick();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_chan !== 2'd1 || pend !== 4'h0) begin
      n_err++;
      $display("FAIL hold_drain: valid=%b chan=%0d pend=%h, need 1/1/0", evt_valid, evt_chan, pend);
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_idle: valid=%b, need 0", evt_valid);
    end
  endtask

  task automatic test_enable();
    do_reset();
    evt_ready = 1'b1;
    en = 1'b0;
    tick();
    din = 4'h7;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) en = 1'b1;
      tick();
      n_cmp++;
      if (pend !== 4'h0 || evt_valid !== 1'b0 || drop !== 1'b0) begin
        n_err++;
        $display("FAIL enable_mask cyc%0d: pend=%h valid=%b drop=%b, need 0/0/0",
                 c, pend, evt_valid, drop);
      end
    end
  endtask

`ifdef NEGEDGE_ARB_DROP_CNT_EN
  task automatic test_drop_cnt();
    do_reset();
    tick();
    for (int i = 0; i < 700; i++) begin
      din = (i % 2 == 1) ? 4'hF : 4'hE;
      tick();
    end
    n_cmp++;
    if (drop_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL dropcnt_sat: drop_cnt=%0d, need 255", drop_cnt);
    end
    din = 4'hE;
    drop_cnt_clr = 1'b1;
    tick();
    drop_cnt_clr = 1'b0;
    n_cmp++;
    if (drop_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL dropcnt_clr: drop_cnt=%0d, need 0", drop_cnt);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      din = 4'($urandom);
      en = ($urandom_range(0, 7) != 0);
      evt_ready = (c % 200 < 60) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      drop_cnt_clr = ($urandom_range(0, 99) == 0);
      tick();
      n_cmp++;
      if (evt_valid !== m_valid || (m_valid && evt_chan !== 2'(m_chan))) begin
        n_err++;
        $display("FAIL rand_evt cyc%0d: valid=%b chan=%0d, need %b/%0d",
                 c, evt_valid, evt_chan, m_valid, m_chan);
      end
      n_cmp++;
      if (pend !== model_pend() || drop !== m_drop) begin
        n_err++;
        $display("FAIL rand_pend cyc%0d: pend=%h drop=%b, need %h/%b",
                 c, pend, drop, model_pend(), m_drop);
      end
`ifdef NEGEDGE_ARB_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 8'(m_cnt)) begin
        n_err++;
        $display("FAIL rand_cnt cyc%0d: drop_cnt=%0d, need %0d", c, drop_cnt, m_cnt);
      end
`endif
    end
    drop_cnt_clr = 1'b0;
  endtask

  task automatic test_reset_mid_handshake();
    bit seen;
    seen = 1'b0;
    evt_ready = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      din = (c % 2 == 0) ? 4'h0 : 4'hF;
      tick();
      seen = m_valid;
    end
    n_cmp++;
    if (!seen || evt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_setup: valid=%b, need 1 within 20 cycles", evt_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (evt_valid !== 1'b0 || pend !== 4'h0) begin
      n_err++;
      $display("FAIL midrst_async: valid=%b pend=%h, need 0/0", evt_valid, pend);
    end
    din = 4'hF;
    tick();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0 || pend !== 4'h0) begin
      n_err++;
      $display("FAIL midrst_lost: valid=%b pend=%h, need 0/0", evt_valid, pend);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_all_fall();
    test_hold_drop();
    test_enable();
`ifdef NEGEDGE_ARB_DROP_CNT_EN
    test_drop_cnt();
`endif
    test_random();
    test_reset_mid_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
